// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between two data-memory requesters
// (A = CPU load/store, B = loader/debug) that share one data memory.
// One access takes three cycles: IDLE (arbitrate and capture), ACCESS
// (drive the memory, gnt high) and RESP (rvalid high, requests ignored).
//
// Ports:
//   SYS_clk, SYS_reset          clock; asynchronous active-high reset
//   X_req/we/len/signed/addr/wdata   command from requester X (A or B)
//   X_gnt, X_rvalid, X_rdata, X_err  grant pulse and response to requester X
//   MEM_write_*, MEM_read_*     data-memory command (length 00 = idle)
//   MEM_read_data               combinational memory read result
//
// Optional build macro: DMEM_MISALIGN_CHECK_EN turns a misaligned half-word
// or word access into an error access. Without it, misaligned addresses go to
// the memory unchanged.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              A_req,
    input  logic              A_we,
    input  logic [1:0]        A_len,
    input  logic              A_signed,
    input  logic [ADDR_W-1:0] A_addr,
    input  logic [31:0]       A_wdata,
    output logic              A_gnt,
    output logic              A_rvalid,
    output logic [31:0]       A_rdata,
    output logic              A_err,
    input  logic              B_req,
    input  logic              B_we,
    input  logic [1:0]        B_len,
    input  logic              B_signed,
    input  logic [ADDR_W-1:0] B_addr,
    input  logic [31:0]       B_wdata,
    output logic              B_gnt,
    output logic              B_rvalid,
    output logic [31:0]       B_rdata,
    output logic              B_err,
    output logic [1:0]        MEM_write_length,
    output logic [1:0]        MEM_read_length,
    output logic              MEM_read_signed,
    output logic [ADDR_W-1:0] MEM_write_address,
    output logic [ADDR_W-1:0] MEM_read_address,
    output logic [31:0]       MEM_write_data,
    input  logic [31:0]       MEM_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_d;

    // last_b = 1 when B held the most recent grant
    logic last_b, last_b_d;
    // captured command attributes still needed after the grant edge
    logic cmd_b, cmd_b_d;
    logic cmd_we, cmd_we_d;
    logic cmd_err, cmd_err_d;

    logic              a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d, a_err_d, b_err_d;
    logic [31:0]       a_rdata_d, b_rdata_d;
    logic [1:0]        mem_wlen_d, mem_rlen_d;
    logic              mem_rsigned_d;
    logic [ADDR_W-1:0] mem_waddr_d, mem_raddr_d;
    logic [31:0]       mem_wdata_d;

    // winner's command, selected combinationally in IDLE
    logic              sel_b, sel_we, sel_signed, sel_err;
    logic [1:0]        sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // Round-robin pick: B wins when alone, or when both ask and A went last.
    always_comb begin
        sel_b      = B_req && (!A_req || !last_b);
        sel_we     = sel_b ? B_we     : A_we;
        sel_len    = sel_b ? B_len    : A_len;
        sel_signed = sel_b ? B_signed : A_signed;
        sel_addr   = sel_b ? B_addr   : A_addr;
        sel_wdata  = sel_b ? B_wdata  : A_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
        sel_err    = (sel_len == 2'b00)
                   || (sel_len == 2'b10 && sel_addr[0])
                   || (sel_len == 2'b11 && sel_addr[1:0] != 2'b00);
`else
        sel_err    = (sel_len == 2'b00);
`endif
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d       = state;
        last_b_d      = last_b;
        cmd_b_d       = cmd_b;
        cmd_we_d      = cmd_we;
        cmd_err_d     = cmd_err;
        a_gnt_d       = 1'b0;
        b_gnt_d       = 1'b0;
        a_rvalid_d    = 1'b0;
        b_rvalid_d    = 1'b0;
        a_rdata_d     = A_rdata;
        b_rdata_d     = B_rdata;
        a_err_d       = A_err;
        b_err_d       = B_err;
        mem_wlen_d    = 2'b00;
        mem_rlen_d    = 2'b00;
        mem_rsigned_d = 1'b0;
        mem_waddr_d   = '0;
        mem_raddr_d   = '0;
        mem_wdata_d   = '0;

        case (state)
            IDLE: begin
                if (A_req || B_req) begin
                    state_d   = ACCESS;
                    last_b_d  = sel_b;
                    cmd_b_d   = sel_b;
                    cmd_we_d  = sel_we;
                    cmd_err_d = sel_err;
                    a_gnt_d   = !sel_b;
                    b_gnt_d   = sel_b;
                    // the MEM_ registers act as the command latch for ACCESS
                    if (!sel_err) begin
                        if (sel_we) begin
                            mem_wlen_d  = sel_len;
                            mem_waddr_d = sel_addr;
                            mem_wdata_d = sel_wdata;
                        end else begin
                            mem_rlen_d    = sel_len;
                            mem_rsigned_d = sel_signed;
                            mem_raddr_d   = sel_addr;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (cmd_b) begin
                    b_rvalid_d = 1'b1;
                    b_err_d    = cmd_err;
                    b_rdata_d  = (!cmd_we && !cmd_err) ? MEM_read_data : 32'h0;
                end else begin
                    a_rvalid_d = 1'b1;
                    a_err_d    = cmd_err;
                    a_rdata_d  = (!cmd_we && !cmd_err) ? MEM_read_data : 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Command attributes, round-robin pointer and output registers.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            last_b            <= 1'b1;
            cmd_b             <= 1'b0;
            cmd_we            <= 1'b0;
            cmd_err           <= 1'b0;
            A_gnt             <= 1'b0;
            B_gnt             <= 1'b0;
            A_rvalid          <= 1'b0;
            B_rvalid          <= 1'b0;
            A_rdata           <= 32'h0;
            B_rdata           <= 32'h0;
            A_err             <= 1'b0;
            B_err             <= 1'b0;
            MEM_write_length  <= 2'b00;
            MEM_read_length   <= 2'b00;
            MEM_read_signed   <= 1'b0;
            MEM_write_address <= '0;
            MEM_read_address  <= '0;
            MEM_write_data    <= 32'h0;
        end else begin
            last_b            <= last_b_d;
            cmd_b             <= cmd_b_d;
            cmd_we            <= cmd_we_d;
            cmd_err           <= cmd_err_d;
            A_gnt             <= a_gnt_d;
            B_gnt             <= b_gnt_d;
            A_rvalid          <= a_rvalid_d;
            B_rvalid          <= b_rvalid_d;
            A_rdata           <= a_rdata_d;
            B_rdata           <= b_rdata_d;
            A_err             <= a_err_d;
            B_err             <= b_err_d;
            MEM_write_length  <= mem_wlen_d;
            MEM_read_length   <= mem_rlen_d;
            MEM_read_signed   <= mem_rsigned_d;
            MEM_write_address <= mem_waddr_d;
            MEM_read_address  <= mem_raddr_d;
            MEM_write_data    <= mem_wdata_d;
        end
    end

endmodule
